// File: rtl/xadc_channel_sequencer.sv
// Time-shares the XADC between two auxiliary channels over DRP: selects a channel,
// waits for end of conversion, reads the result and strobes it to that channel's monitor.
module xadc_channel_sequencer #(
    parameter logic [6:0]  CH0_ADDR       = 7'h16,
    parameter logic [6:0]  CH1_ADDR       = 7'h1E,
    parameter logic [15:0] CFG0_BASE      = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    output logic [6:0]  drp_daddr_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    input  logic        eoc_i,
    output logic [15:0] ch0_data_o,
    output logic [15:0] ch1_data_o,
    output logic        ch0_ready_o,
    output logic        ch1_ready_o,
    output logic        active_ch_o,
    output logic        timeout_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        CFG_WAIT,
        CONV_WAIT,
        RD,
        RD_WAIT
    } state_t;

    localparam logic [6:0]  CFG0_ADDR    = 7'h40;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [15:0] di_q, di_d;
    logic [15:0] ch0_data_q, ch0_data_d;
    logic [15:0] ch1_data_q, ch1_data_d;
    logic        ch0_ready_q, ch0_ready_d;
    logic        ch1_ready_q, ch1_ready_d;
    logic        active_q, active_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic [6:0]  ch_addr;
    logic        timed_out;

    assign ch_addr   = active_q ? CH1_ADDR : CH0_ADDR;
    assign timed_out = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        daddr_d     = daddr_q;
        den_d       = 1'b0;
        dwe_d       = 1'b0;
        di_d        = di_q;
        ch0_data_d  = ch0_data_q;
        ch1_data_d  = ch1_data_q;
        ch0_ready_d = 1'b0;
        ch1_ready_d = 1'b0;
        active_d    = active_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = CFG_WR;
            end
            CFG_WR: begin
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                daddr_d = CFG0_ADDR;
                di_d    = {CFG0_BASE[15:5], ch_addr[4:0]};
                cnt_d   = '0;
                state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (drp_drdy_i) begin
                    cnt_d   = '0;
                    state_d = CONV_WAIT;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = CFG_WR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CONV_WAIT: begin
                if (eoc_i) begin
                    state_d = RD;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = CFG_WR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RD: begin
                den_d   = 1'b1;
                daddr_d = ch_addr;
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // The awaited response takes priority over a timeout expiring in the same cycle.
                if (drp_drdy_i) begin
                    if (active_q) begin
                        ch1_data_d  = drp_do_i;
                        ch1_ready_d = 1'b1;
                    end else begin
                        ch0_data_d  = drp_do_i;
                        ch0_ready_d = 1'b1;
                    end
                    active_d = ~active_q;
                    state_d  = enable_i ? CFG_WR : IDLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = CFG_WR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            daddr_q     <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            di_q        <= '0;
            ch0_data_q  <= '0;
            ch1_data_q  <= '0;
            ch0_ready_q <= 1'b0;
            ch1_ready_q <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            daddr_q     <= daddr_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            di_q        <= di_d;
            ch0_data_q  <= ch0_data_d;
            ch1_data_q  <= ch1_data_d;
            ch0_ready_q <= ch0_ready_d;
            ch1_ready_q <= ch1_ready_d;
            active_q    <= active_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign drp_daddr_o   = daddr_q;
    assign drp_den_o     = den_q;
    assign drp_dwe_o     = dwe_q;
    assign drp_di_o      = di_q;
    assign ch0_data_o    = ch0_data_q;
    assign ch1_data_o    = ch1_data_q;
    assign ch0_ready_o   = ch0_ready_q;
    assign ch1_ready_o   = ch1_ready_q;
    assign active_ch_o   = active_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_xadc_channel_sequencer.sv
// Scoreboard bench for xadc_channel_sequencer: a DRP/XADC responder model plus queues of
// expected DRP transactions and channel results, compared as the DUT produces them.
module tb_xadc_channel_sequencer;

    typedef struct {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] di;
    } drp_t;

    typedef struct {
        logic        ch;
        logic [15:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic [6:0]  drp_daddr_o;
    logic        drp_den_o;
    logic        drp_dwe_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i;
    logic        drp_drdy_i;
    logic        eoc_i;
    logic [15:0] ch0_data_o, ch1_data_o;
    logic        ch0_ready_o, ch1_ready_o;
    logic        active_ch_o;
    logic        timeout_err_o;

    logic auto_eoc, man_eoc;
    assign eoc_i = auto_eoc | man_eoc;

    xadc_channel_sequencer #(
        .CH0_ADDR      (7'h16),
        .CH1_ADDR      (7'h1E),
        .CFG0_BASE     (16'h0000),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable_i),
        .drp_daddr_o  (drp_daddr_o),
        .drp_den_o    (drp_den_o),
        .drp_dwe_o    (drp_dwe_o),
        .drp_di_o     (drp_di_o),
        .drp_do_i     (drp_do_i),
        .drp_drdy_i   (drp_drdy_i),
        .eoc_i        (eoc_i),
        .ch0_data_o   (ch0_data_o),
        .ch1_data_o   (ch1_data_o),
        .ch0_ready_o  (ch0_ready_o),
        .ch1_ready_o  (ch1_ready_o),
        .active_ch_o  (active_ch_o),
        .timeout_err_o(timeout_err_o)
    );

    initial forever #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [15:0] resp(input logic [6:0] addr);
        if (addr == 7'h16) return 16'h1234;
        if (addr == 7'h1E) return 16'hABCD;
        return 16'h0000;
    endfunction

    // DRP / XADC responder: drdy 2 cycles after a write, rd_dly after a read; eoc 10 after a config write.
    int         pend = 0;
    logic       pend_rd = 1'b0;
    logic [6:0] pend_addr = '0;
    int         eoc_cnt = 0;
    int         rd_dly = 2;
    logic       eoc_en = 1'b1;

    initial begin
        drp_drdy_i = 1'b0;
        drp_do_i   = '0;
        auto_eoc   = 1'b0;
        forever begin
            @(negedge clk);
            drp_drdy_i = 1'b0;
            drp_do_i   = '0;
            auto_eoc   = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = pend_rd ? resp(pend_addr) : 16'h0000;
                    if (!reset) check("drp_addr_hold", 32'(drp_daddr_o), 32'(pend_addr));
                end
            end
            if (eoc_cnt > 0) begin
                eoc_cnt--;
                if (eoc_cnt == 0) auto_eoc = 1'b1;
            end
            if (drp_den_o === 1'b1) begin
                pend_rd   = !drp_dwe_o;
                pend_addr = drp_daddr_o;
                pend      = drp_dwe_o ? 2 : rd_dly;
                if (drp_dwe_o && eoc_en) eoc_cnt = 10;
            end
        end
    end

    // Scoreboard monitor.
    drp_t exp_drp[$];
    res_t exp_res[$];
    int   cyc = 0;
    int   cfg_den_cnt = 0;
    int   rd_den_cnt = 0;
    int   prev_cfg_cyc = 0;
    int   last_cfg_cyc = 0;

    initial begin
        drp_t e;
        res_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (drp_den_o === 1'b1) begin
                if (drp_dwe_o) begin
                    cfg_den_cnt++;
                    prev_cfg_cyc = last_cfg_cyc;
                    last_cfg_cyc = cyc;
                end else begin
                    rd_den_cnt++;
                end
                if (exp_drp.size() == 0) begin
                    check("den_unexpected", 32'(drp_den_o), 32'd0);
                end else begin
                    e = exp_drp.pop_front();
                    check("den_addr", 32'(drp_daddr_o), 32'(e.addr));
                    check("den_we", 32'(drp_dwe_o), 32'(e.we));
                    if (e.we) check("cfg_di", 32'(drp_di_o), 32'(e.di));
                end
            end
            if (drp_dwe_o === 1'b1 && drp_den_o !== 1'b1) check("dwe_without_den", 32'(drp_dwe_o), 32'd0);
            if (ch0_ready_o === 1'b1 || ch1_ready_o === 1'b1) begin
                check("ready_excl", 32'(ch0_ready_o & ch1_ready_o), 32'd0);
                if (exp_res.size() == 0) begin
                    check("ready_unexpected", 32'({ch1_ready_o, ch0_ready_o}), 32'd0);
                end else begin
                    r = exp_res.pop_front();
                    check("ready_ch", 32'(ch1_ready_o), 32'(r.ch));
                    check("ready_data", 32'(r.ch ? ch1_data_o : ch0_data_o), 32'(r.data));
                    check("active_toggle", 32'(active_ch_o), 32'(!r.ch));
                end
            end
        end
    end

    task automatic push_drp(input logic [6:0] addr, input logic we, input logic [15:0] di);
        drp_t e;
        e.addr = addr;
        e.we   = we;
        e.di   = di;
        exp_drp.push_back(e);
    endtask

    task automatic push_res(input logic ch, input logic [15:0] data);
        res_t r;
        r.ch   = ch;
        r.data = data;
        exp_res.push_back(r);
    endtask

    task automatic wait_rd(input int target, input string tag);
        for (int i = 0; i < 400 && rd_den_cnt < target; i++) @(negedge clk);
        check(tag, 32'(rd_den_cnt >= target), 32'd1);
    endtask

    task automatic wait_cfg(input int target, input string tag);
        for (int i = 0; i < 400 && cfg_den_cnt < target; i++) @(negedge clk);
        check(tag, 32'(cfg_den_cnt >= target), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && (exp_res.size() != 0 || exp_drp.size() != 0); i++) @(negedge clk);
        check(tag, 32'(exp_res.size() + exp_drp.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_daddr"}, 32'(drp_daddr_o), 32'd0);
        check({pfx, "_den"}, 32'(drp_den_o), 32'd0);
        check({pfx, "_dwe"}, 32'(drp_dwe_o), 32'd0);
        check({pfx, "_di"}, 32'(drp_di_o), 32'd0);
        check({pfx, "_ch0_data"}, 32'(ch0_data_o), 32'd0);
        check({pfx, "_ch1_data"}, 32'(ch1_data_o), 32'd0);
        check({pfx, "_ch0_ready"}, 32'(ch0_ready_o), 32'd0);
        check({pfx, "_ch1_ready"}, 32'(ch1_ready_o), 32'd0);
        check({pfx, "_active"}, 32'(active_ch_o), 32'd0);
        check({pfx, "_err"}, 32'(timeout_err_o), 32'd0);
    endtask

    initial begin
        int base_rd;
        int base_cfg;
        man_eoc = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Normal alternation, then disable during the second read.
        push_drp(7'h40, 1'b1, 16'h0016);
        push_drp(7'h16, 1'b0, 16'h0000);
        push_res(1'b0, 16'h1234);
        push_drp(7'h40, 1'b1, 16'h001E);
        push_drp(7'h1E, 1'b0, 16'h0000);
        push_res(1'b1, 16'hABCD);
        enable_i = 1'b1;
        wait_rd(2, "alt_rd_wait");
        enable_i = 1'b0;
        wait_drain("alt_drain");
        repeat (10) @(negedge clk);
        check("alt_no_more_den", 32'(cfg_den_cnt), 32'd2);
        check("alt_ch0_stable", 32'(ch0_data_o), 32'h1234);
        check("alt_ch1_data", 32'(ch1_data_o), 32'hABCD);

        // Early eoc during CFG_WAIT is ignored.
        eoc_en = 1'b0;
        base_rd = rd_den_cnt;
        push_drp(7'h40, 1'b1, 16'h0016);
        enable_i = 1'b1;
        wait_cfg(3, "early_cfg_wait");
        man_eoc = 1'b1;
        @(negedge clk);
        man_eoc = 1'b0;
        repeat (8) @(negedge clk);
        check("early_no_read", 32'(rd_den_cnt), 32'(base_rd));
        push_drp(7'h16, 1'b0, 16'h0000);
        push_res(1'b0, 16'h1234);
        man_eoc = 1'b1;
        @(negedge clk);
        man_eoc = 1'b0;
        wait_rd(base_rd + 1, "early_rd_wait");
        enable_i = 1'b0;
        wait_drain("early_drain");
        repeat (4) @(negedge clk);

        // Timeout in CONV_WAIT: err sets, same channel config is retried.
        base_rd  = rd_den_cnt;
        base_cfg = cfg_den_cnt;
        push_drp(7'h40, 1'b1, 16'h001E);
        push_drp(7'h40, 1'b1, 16'h001E);
        push_drp(7'h1E, 1'b0, 16'h0000);
        push_res(1'b1, 16'hABCD);
        enable_i = 1'b1;
        wait_cfg(base_cfg + 1, "to_cfg1_wait");
        repeat (5) @(negedge clk);
        check("to_err_before", 32'(timeout_err_o), 32'd0);
        eoc_en = 1'b1;
        wait_cfg(base_cfg + 2, "to_cfg2_wait");
        check("to_retry_gap", 32'(last_cfg_cyc - prev_cfg_cyc), 32'd24);
        check("to_err_set", 32'(timeout_err_o), 32'd1);
        check("to_same_ch", 32'(active_ch_o), 32'd1);
        wait_rd(base_rd + 1, "to_rd_wait");
        enable_i = 1'b0;
        wait_drain("to_drain");
        check("to_err_sticky", 32'(timeout_err_o), 32'd1);
        repeat (4) @(negedge clk);

        // Reset during CFG_WAIT of channel 1.
        base_cfg = cfg_den_cnt;
        push_drp(7'h40, 1'b1, 16'h0016);
        push_drp(7'h16, 1'b0, 16'h0000);
        push_res(1'b0, 16'h1234);
        push_drp(7'h40, 1'b1, 16'h001E);
        enable_i = 1'b1;
        wait_cfg(base_cfg + 2, "rst_cfg_wait");
        reset    = 1'b1;
        enable_i = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        check("rst_late_drdy_ignored", 32'(ch1_ready_o | ch0_ready_o), 32'd0);

        // After reset: channel 0, and drdy on the exact timeout cycle in RD_WAIT.
        base_rd = rd_den_cnt;
        rd_dly  = 19;
        push_drp(7'h40, 1'b1, 16'h0016);
        push_drp(7'h16, 1'b0, 16'h0000);
        push_res(1'b0, 16'h1234);
        reset    = 1'b0;
        enable_i = 1'b1;
        wait_rd(base_rd + 1, "evt_rd_wait");
        enable_i = 1'b0;
        wait_drain("evt_drain");
        check("evt_err_clear", 32'(timeout_err_o), 32'd0);
        check("evt_ch0_data", 32'(ch0_data_o), 32'h1234);
        repeat (10) @(negedge clk);
        check("final_queues", 32'(exp_drp.size() + exp_res.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
